inst_queue: RTL and testbench

- Circular instruction FIFO directly upstream of the dispatcher's decode/immediate-generation logic.
- Fetch pushes {pc, inst} pairs; the dispatcher pops them in order.
- Absorbs fetch/dispatch rate mismatch.
- Supports a single-cycle flush on branch mispredict/redirect.

---
 rtl/dispatcher_pkg.sv | 18 +
 rtl/inst_queue.sv | 55 +++++
 tb/tb_inst_queue.sv | 138 +++++++++++++
 3 files changed

// File: rtl/dispatcher_pkg.sv
// dispatcher_pkg: shared constants and entry type for the instruction queue and decode/immediate logic
package dispatcher_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [6:0] OP = 7'h33;
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] LOAD = 7'h03;
  localparam logic [6:0] STORE = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] JAL = 7'h6F;
  localparam logic [6:0] JALR = 7'h67;
  localparam logic [6:0] LUI = 7'h37;
  localparam logic [6:0] AUIPC = 7'h17;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } iq_entry_t;
endpackage

// File: rtl/inst_queue.sv
// inst_queue: show-ahead circular {pc, inst} FIFO between fetch and dispatch, with single-cycle flush
//   clk/rst_n: clock, async active-low reset; flush: drop all entries
//   wr_en/wr_pc/wr_inst/full: fetch push side; rd_en/rd_valid/rd_pc/rd_inst/empty: dispatch pop side
//   count: current occupancy
module inst_queue
  import dispatcher_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN = dispatcher_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [XLEN-1:0]          wr_pc,
  input  logic [XLEN-1:0]          wr_inst,
  output logic                     full,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [XLEN-1:0]          rd_pc,
  output logic [XLEN-1:0]          rd_inst,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  iq_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign count = r_count;
  assign full = r_count == (AW+1)'(DEPTH);
  assign empty = r_count == '0;
  assign rd_valid = ~empty;
  assign w_push = wr_en & ~full & ~flush;
  assign w_pop = rd_en & ~empty & ~flush;
  // empty mux hides unwritten storage and feeds decode a harmless NOP
  assign rd_pc = empty ? '0 : r_mem[r_rd_ptr].pc;
  assign rd_inst = empty ? NOP_INST : r_mem[r_rd_ptr].inst;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= '{pc: wr_pc, inst: wr_inst};
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed stimulus with queue-based reference model and per-cycle comparison
module tb_inst_queue;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0, rst_n = 0, flush = 0, wr_en = 0, rd_en = 0;
  logic [31:0] wr_pc = 0, wr_inst = 0;
  logic full, rd_valid, empty;
  logic [31:0] rd_pc, rd_inst;
  logic [3:0] count;
  int n_pass = 0, n_total = 0;
  logic [63:0] q[$];

  inst_queue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_pc(wr_pc),
    .wr_inst(wr_inst), .full(full), .rd_en(rd_en), .rd_valid(rd_valid),
    .rd_pc(rd_pc), .rd_inst(rd_inst), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'h0010_0093 + ((pc - 32'h100) >> 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    chk("m_count", 32'(count), 32'(q.size()));
    chk("m_empty", 32'(empty), 32'(q.size() == 0));
    chk("m_full", 32'(full), 32'(q.size() == 8));
    chk("m_valid", 32'(rd_valid), 32'(q.size() != 0));
    chk("m_pc", rd_pc, q.size() ? q[0][63:32] : 32'h0);
    chk("m_inst", rd_inst, q.size() ? q[0][31:0] : NOP);
  end

  task automatic step(input logic f, input logic w, input logic [31:0] pc, input logic r);
    logic pu, po;
    flush = f; wr_en = w; wr_pc = pc; wr_inst = inst_of(pc); rd_en = r;
    @(posedge clk);
    if (f) q.delete();
    else begin
      pu = w && q.size() < 8;
      po = r && q.size() > 0;
      if (po) void'(q.pop_front());
      if (pu) q.push_back({pc, inst_of(pc)});
    end
    #1;
    flush = 0; wr_en = 0; rd_en = 0;
  endtask

  initial begin
    logic [31:0] exp_pcs [7];
    exp_pcs = '{32'h208, 32'h20C, 32'h210, 32'h214, 32'h218, 32'h21C, 32'h220};
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_inst", rd_inst, NOP);
    chk("rst_pc", rd_pc, 0);
    for (int k = 0; k < 8; k++) begin
      step(0, 1, 32'h100 + 4 * k, 0);
      chk("fill_count", 32'(count), k + 1);
    end
    chk("fill_full", 32'(full), 1);
    step(0, 1, 32'h120, 0);
    chk("drop_count", 32'(count), 8);
    chk("drop_head", rd_pc, 32'h100);
    chk("drop_inst", rd_inst, 32'h0010_0093);
    for (int k = 0; k < 8; k++) begin
      chk("drain_pc", rd_pc, 32'h100 + 4 * k);
      step(0, 0, 0, 1);
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_nop", rd_inst, NOP);
    step(0, 0, 0, 1);
    chk("pop_empty_count", 32'(count), 0);
    step(0, 1, 32'h200, 1);
    chk("nobypass_count", 32'(count), 1);
    chk("nobypass_pc", rd_pc, 32'h200);
    step(0, 1, 32'h204, 0);
    step(0, 1, 32'h208, 0);
    step(0, 1, 32'h20C, 1);
    chk("pp3_count", 32'(count), 3);
    chk("pp3_head", rd_pc, 32'h204);
    for (int k = 0; k < 5; k++) step(0, 1, 32'h210 + 4 * k, 0);
    chk("refill_full", 32'(full), 1);
    step(0, 1, 32'h300, 1);
    chk("ppfull_count", 32'(count), 7);
    for (int k = 0; k < 7; k++) begin
      chk("ppfull_pc", rd_pc, exp_pcs[k]);
      step(0, 0, 0, 1);
    end
    chk("ppfull_empty", 32'(empty), 1);
    step(0, 1, 32'h400, 0);
    step(0, 1, 32'h404, 0);
    for (int i = 0; i < 20; i++) begin
      chk("wrap_pc", rd_pc, 32'h400 + 4 * i);
      chk("wrap_count", 32'(count), 2);
      step(0, 1, 32'h408 + 4 * i, 1);
    end
    chk("wrap_tail0", rd_pc, 32'h450);
    step(0, 0, 0, 1);
    chk("wrap_tail1", rd_pc, 32'h454);
    step(0, 0, 0, 1);
    for (int k = 0; k < 5; k++) step(0, 1, 32'h500 + 4 * k, 0);
    chk("pre_flush_count", 32'(count), 5);
    step(1, 1, 32'h600, 1);
    chk("flush_count", 32'(count), 0);
    chk("flush_empty", 32'(empty), 1);
    chk("flush_inst", rd_inst, NOP);
    step(0, 1, 32'h700, 0);
    chk("post_flush_pc", rd_pc, 32'h700);
    chk("post_flush_valid", 32'(rd_valid), 1);
    step(0, 1, 32'h704, 0);
    step(0, 1, 32'h708, 0);
    #2 rst_n = 0;
    q.delete();
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_valid", 32'(rd_valid), 0);
    chk("arst_inst", rd_inst, NOP);
    chk("arst_pc", rd_pc, 0);
    @(posedge clk);
    #3 rst_n = 1;
    step(0, 1, 32'h800, 0);
    chk("arst_push_pc", rd_pc, 32'h800);
    chk("arst_push_count", 32'(count), 1);
    @(negedge clk);
    #1 $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
